// File: rtl/display_scanner_pkg.sv
// Shared constants, segment lookup table and enable helper for the 4-digit display scanner.
package display_pkg;

    localparam int SEG_W = 7;
    localparam int DIG_N = 4;
    localparam int NIB_W = 4;

    // Segment order {A,B,C,D,E,F,G}, active-high, indexed by hex value.
    localparam logic [SEG_W-1:0] SEG7_LUT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    localparam logic [DIG_N-1:0] DS_EN_OFF = 4'b1111;

    typedef enum logic {
        SLOT_BLANK,
        SLOT_DRIVE
    } slot_state_t;

    function automatic logic [DIG_N-1:0] en_mask(input logic [1:0] idx);
        en_mask = ~(DIG_N'(1) << idx);
    endfunction

endpackage

// File: rtl/display_scanner_seg7_decode.sv
// Combinational hex nibble to 7-segment pattern decoder.
module seg7_decode
    import display_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] segments
);

    assign segments = SEG7_LUT[nibble];

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 4-digit 7-segment scanner with frame-aligned value update and blanking gap.
// Optional leading-zero blanking when DISPLAY_SCANNER_LZ_BLANK_EN is defined.
module display_scanner
    import display_pkg::*;
#(
    parameter int DIV_W        = 12,
    parameter int BLANK_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [15:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DIG_N-1:0]  DS_EN,
    output logic [SEG_W-1:0]  DS_SEG
);

    localparam logic [DIV_W-1:0] PHASE_LAST = '1;
    localparam logic [DIV_W-1:0] BLANK_PH   = DIV_W'(BLANK_CYCLES);

    logic [DIV_W-1:0] phaseReg;
    logic [1:0]       idxReg;
    logic [15:0]      pendingReg;
    logic [15:0]      shownReg;
    logic             pendingValidReg;

    slot_state_t      slotState;
    logic             frameEnd;
    logic             accept;
    logic [NIB_W-1:0] nibble;
    logic [SEG_W-1:0] segDecoded;
    logic [DIG_N-1:0] digitKeep;
    logic [DIG_N-1:0] enNext;
    logic [SEG_W-1:0] segNext;

    assign in_ready = !pendingValidReg;
    assign accept   = in_valid && !pendingValidReg;
    assign frameEnd = (idxReg == 2'd3) && (phaseReg == PHASE_LAST);
    assign nibble   = shownReg[{idxReg, 2'b00} +: NIB_W];

    seg7_decode u_seg7_decode (
        .nibble   (nibble),
        .segments (segDecoded)
    );

    // Digit 0 is always lit; higher digits may be suppressed when everything above is zero.
    genvar gi;
    generate
        for (gi = 0; gi < DIG_N; gi++) begin : g_keep
            if (gi == 0) begin : g_first
                assign digitKeep[gi] = 1'b1;
            end else begin : g_rest
`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
                assign digitKeep[gi] = |shownReg[15:NIB_W*gi];
`else
                assign digitKeep[gi] = 1'b1;
`endif
            end
        end
    endgenerate

    always_comb begin
        slotState = (phaseReg < BLANK_PH) ? SLOT_BLANK : SLOT_DRIVE;
        enNext    = DS_EN_OFF;
        segNext   = '0;
        if (slotState == SLOT_DRIVE && digitKeep[idxReg]) begin
            enNext  = en_mask(idxReg);
            segNext = segDecoded;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phaseReg        <= '0;
            idxReg          <= '0;
            pendingReg      <= '0;
            shownReg        <= '0;
            pendingValidReg <= 1'b0;
            DS_EN           <= DS_EN_OFF;
            DS_SEG          <= '0;
        end else begin
            phaseReg <= phaseReg + DIV_W'(1);
            if (phaseReg == PHASE_LAST) begin
                idxReg <= idxReg + 2'd1;
            end
            // An accept can only occur with the buffer empty, so it never collides with a swap.
            if (accept) begin
                pendingReg      <= in_data;
                pendingValidReg <= 1'b1;
            end else if (frameEnd && pendingValidReg) begin
                shownReg        <= pendingReg;
                pendingValidReg <= 1'b0;
            end
            DS_EN  <= enNext;
            DS_SEG <= segNext;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: cycle-count reference model plus directed and random stimulus.
`timescale 1ns/1ps
module tb_display_scanner;

    localparam int DIV_W        = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int SLOT         = 1 << DIV_W;
    localparam int FRAME        = 4 * SLOT;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  DS_EN;
    logic [6:0]  DS_SEG;

    display_scanner #(.DIV_W(DIV_W), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .DS_EN    (DS_EN),
        .DS_SEG   (DS_SEG)
    );

    always #5 CLK = ~CLK;

    int nCompared = 0;
    int nMismatch = 0;
    int nAccepts  = 0;

    // Reference state: cycles since reset release, displayed value, waiting values.
    int          mT = 0;
    logic [15:0] mShown = 16'h0000;
    logic [15:0] mPend[$];
    logic [3:0]  expEn = 4'hF;
    logic [6:0]  expSeg = 7'h00;
    logic        expReady = 1'b1;
    bit          modelLive = 0;

    function automatic logic [6:0] segOf(logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    function automatic bit digitVisible(logic [15:0] v, int k);
        bit lz = 0;
`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
        lz = 1;
`endif
        return (k == 0) || !lz || ((v >> (4 * k)) != 16'h0000);
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, mT);
        end
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            mT = 0;
            mShown = 16'h0000;
            mPend.delete();
            expEn = 4'hF;
            expSeg = 7'h00;
        end else begin
            int ph;
            int id;
            bit acc;
            ph = mT % SLOT;
            id = (mT / SLOT) % 4;
            expEn = 4'hF;
            expSeg = 7'h00;
            if (ph >= BLANK_CYCLES && digitVisible(mShown, id)) begin
                expEn  = 4'hF ^ (4'b0001 << id);
                expSeg = segOf(mShown[id*4 +: 4]);
            end
            acc = in_valid && (mPend.size() == 0);
            if ((mT % FRAME) == FRAME - 1 && mPend.size() != 0) begin
                mShown = mPend.pop_front();
                $display("frame end t=%0d now showing %h", mT, mShown);
            end
            if (acc) begin
                mPend.push_back(in_data);
                nAccepts++;
                $display("accept #%0d t=%0d data=%h", nAccepts, mT, in_data);
            end
            mT++;
        end
        expReady = (mPend.size() == 0);
        modelLive = 1;
    end

    always @(negedge CLK) begin
        if (modelLive) begin
            check("DS_EN", 16'(DS_EN), 16'(expEn));
            check("DS_SEG", 16'(DS_SEG), 16'(expSeg));
            check("in_ready", 16'(in_ready), 16'(expReady));
        end
    end

    // Wait (at negedges) until the outputs reflect slot position 'target'.
    task automatic waitPos(int target);
        int guard = 0;
        while (mT - 1 != target && guard < 4 * FRAME) begin
            @(negedge CLK);
            guard++;
        end
        if (mT - 1 != target) begin
            nCompared++;
            nMismatch++;
            $display("FAIL waitPos: reached %0d, required %0d", mT - 1, target);
        end
    endtask

    task automatic sendValue(logic [15:0] d);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 2 * FRAME) begin
            @(negedge CLK);
            guard++;
        end
        if (!in_ready) begin
            nCompared++;
            nMismatch++;
            $display("FAIL send_timeout: in_ready got 0, expected 1 for data %h", d);
        end
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic pinOut(string name, logic [3:0] en, logic [6:0] seg);
        check({name, "_en"}, 16'(DS_EN), 16'(en));
        check({name, "_seg"}, 16'(DS_SEG), 16'(seg));
    endtask

    initial begin
        int t0;
        int guard;
        logic [15:0] d;

        // Reset held for 3 cycles
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        pinOut("reset", 4'b1111, 7'h00);
        check("reset_ready", 16'(in_ready), 16'h1);
        RST = 1'b0;
        sendValue(16'h12AF);

        waitPos(1);   pinOut("first_blank", 4'b1111, 7'h00);
        waitPos(2);   pinOut("first_digit0", 4'b1110, 7'h7E);
        waitPos(62);  check("ready_held", 16'(in_ready), 16'h0);
        waitPos(63);  check("ready_rise", 16'(in_ready), 16'h1);
        waitPos(65);  pinOut("gap_slot0", 4'b1111, 7'h00);
        waitPos(66);  pinOut("slot0_F", 4'b1110, 7'h47);
        waitPos(80);  pinOut("gap_slot1", 4'b1111, 7'h00);
        waitPos(82);  pinOut("slot1_A", 4'b1101, 7'h77);
        waitPos(98);  pinOut("slot2_2", 4'b1011, 7'h6D);
        waitPos(127); pinOut("slot3_1", 4'b0111, 7'h30);

        // Back-to-back: 0x2222 waits behind 0x1111 with in_valid held
        sendValue(16'h1111);
        sendValue(16'h2222);
        repeat (2 * FRAME) @(negedge CLK);

        // Accept exactly on the frame-end cycle
        guard = 0;
        while (!(in_ready && (mT % FRAME) == FRAME - 1) && guard < 4 * FRAME) begin
            @(negedge CLK);
            guard++;
        end
        t0 = mT;
        in_valid = 1'b1;
        in_data  = 16'h5A3C;
        @(negedge CLK);
        in_valid = 1'b0;
        check("frame_end_accept_ready", 16'(in_ready), 16'h0);
        waitPos(t0 + 3);         pinOut("prev_frame_kept", 4'b1110, 7'h6D);
        waitPos(t0 + FRAME + 3); pinOut("frame_end_value", 4'b1110, 7'h4E);

        // Reset while a value is pending
        sendValue(16'hBEEF);
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        pinOut("midreset", 4'b1111, 7'h00);
        check("midreset_ready", 16'(in_ready), 16'h1);
        RST = 1'b0;
        waitPos(2); pinOut("after_reset", 4'b1110, 7'h7E);

        // Leading zeros
        sendValue(16'h0040);
        waitPos(66);  pinOut("lz_digit0", 4'b1110, 7'h7E);
        waitPos(82);  pinOut("lz_digit1", 4'b1101, 7'h33);
`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
        waitPos(98);  pinOut("lz_digit2", 4'b1111, 7'h00);
        waitPos(114); pinOut("lz_digit3", 4'b1111, 7'h00);
`else
        waitPos(98);  pinOut("lz_digit2", 4'b1011, 7'h7E);
        waitPos(114); pinOut("lz_digit3", 4'b0111, 7'h7E);
`endif

        // Random traffic with occasional resets, checked cycle by cycle against the model
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 80)) @(negedge CLK);
            if ($urandom_range(0, 11) == 0) begin
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
            end
            d = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d = d >> (4 * $urandom_range(1, 3));
            sendValue(d);
        end
        repeat (2 * FRAME) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
